// File: rtl/lcd_pkg.sv
// Shared definitions for the ST7789V3 LCD init path: opcodes, META byte layout, sequencer states.
package lcd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_INVON   = 8'h21;
  localparam logic [7:0] CMD_NORON   = 8'h13;
  localparam logic [7:0] CMD_DISPON  = 8'h29;

  // META byte: [5:0] argument count, [6] long delay, [7] short delay (long wins if both set)
  localparam int         META_LONG_BIT  = 6;
  localparam int         META_SHORT_BIT = 7;
  localparam logic [5:0] META_ARG_MASK  = 6'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_META,
    S_ARG,
    S_DRAIN,
    S_DELAY,
    S_DONE
  } initseq_state_t;

endpackage

// File: rtl/lcd_dly_timer.sv
// Load/count-down delay timer; o_last marks the final cycle of a loaded wait of i_load_val+1 cycles.
// No backpressure: a new i_load restarts the count at any time.
module lcd_dly_timer #(
  parameter int CTR_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CTR_W-1:0] i_load_val,
  output logic             o_last
);

  logic [CTR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CTR_W'(1);
    end
  end

  assign o_last = (r_cnt <= CTR_W'(1));

endmodule

// File: rtl/lcd_initseq_ctrl.sv
// Walks the packed LCD init table and feeds the SPI byte serializer; first CMD byte offered one cycle after start.
// tx_valid/tx_byte hold until tx_ready; post-command delays wait for ser_idle before counting.
module lcd_initseq_ctrl
  import lcd_pkg::*;
#(
  parameter int SEQ_LEN          = 22,
  parameter int LONG_DLY_CYCLES  = 50,
  parameter int SHORT_DLY_CYCLES = 10,
  parameter int CTR_W            = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [$clog2(SEQ_LEN+1)-1:0] rom_addr,
  input  logic [7:0]                   rom_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_byte,
  output logic                         tx_rs,
  input  logic                         ser_idle,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int PTR_W = $clog2(SEQ_LEN+1);
  localparam logic [PTR_W-1:0] END_PTR  = PTR_W'(SEQ_LEN);
  // The DRAIN cycle that sees ser_idle is the first cycle of the delay window.
  localparam logic [CTR_W-1:0] LONG_LD  = CTR_W'(LONG_DLY_CYCLES - 1);
  localparam logic [CTR_W-1:0] SHORT_LD = CTR_W'(SHORT_DLY_CYCLES - 1);

  initseq_state_t   r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [5:0]       r_args;
  logic             r_long;
  logic             r_short;
  logic             r_tx_valid;
  logic             r_tx_rs;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [PTR_W-1:0] w_ptr_inc;
  logic             w_at_end;
  logic             w_inc_at_end;
  logic             w_xfer;
  logic [5:0]       w_meta_n;
  logic             w_meta_dly;
  logic             w_tmr_load;
  logic [CTR_W-1:0] w_tmr_val;
  logic             w_tmr_last;

  assign w_ptr_inc    = r_ptr + PTR_W'(1);
  assign w_at_end     = (r_ptr == END_PTR);
  assign w_inc_at_end = (w_ptr_inc == END_PTR);
  assign w_xfer       = r_tx_valid && tx_ready;
  assign w_meta_n     = rom_data[5:0] & META_ARG_MASK;
  assign w_meta_dly   = rom_data[META_LONG_BIT] | rom_data[META_SHORT_BIT];
  assign w_tmr_load   = (r_state == S_DRAIN) && ser_idle;
  assign w_tmr_val    = r_long ? LONG_LD : SHORT_LD;

  lcd_dly_timer #(.CTR_W(CTR_W)) u_dly (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_last     (w_tmr_last)
  );

  // tx_valid is precomputed on every transition into CMD/ARG so it is low when the table is exhausted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_args     <= '0;
      r_long     <= 1'b0;
      r_short    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_rs    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_ptr      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_valid <= (END_PTR != '0);
            r_tx_rs    <= 1'b0;
            r_state    <= S_CMD;
          end
        end
        S_CMD: begin
          if (w_at_end) begin
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_xfer) begin
            r_ptr      <= w_ptr_inc;
            r_tx_valid <= 1'b0;
            r_state    <= S_META;
          end
        end
        S_META: begin
          if (w_at_end) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_args  <= w_meta_n;
            r_long  <= rom_data[META_LONG_BIT];
            r_short <= rom_data[META_SHORT_BIT];
            r_ptr   <= w_ptr_inc;
            if (w_meta_n != '0) begin
              r_tx_valid <= !w_inc_at_end;
              r_tx_rs    <= 1'b1;
              r_state    <= S_ARG;
            end else if (w_meta_dly) begin
              r_state <= S_DRAIN;
            end else begin
              r_tx_valid <= !w_inc_at_end;
              r_tx_rs    <= 1'b0;
              r_state    <= S_CMD;
            end
          end
        end
        S_ARG: begin
          if (w_at_end) begin
            r_tx_valid <= 1'b0;
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_xfer) begin
            r_ptr  <= w_ptr_inc;
            r_args <= r_args - 6'd1;
            if (r_args != 6'd1) begin
              r_tx_valid <= !w_inc_at_end;
            end else if (r_long || r_short) begin
              r_tx_valid <= 1'b0;
              r_tx_rs    <= 1'b0;
              r_state    <= S_DRAIN;
            end else begin
              r_tx_valid <= !w_inc_at_end;
              r_tx_rs    <= 1'b0;
              r_state    <= S_CMD;
            end
          end
        end
        S_DRAIN: begin
          if (ser_idle) begin
            r_state <= S_DELAY;
          end
        end
        S_DELAY: begin
          if (w_tmr_last) begin
            r_tx_valid <= !w_at_end;
            r_tx_rs    <= 1'b0;
            r_state    <= S_CMD;
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr = r_ptr;
  assign tx_valid = r_tx_valid;
  assign tx_byte  = r_tx_valid ? rom_data : 8'h00;
  assign tx_rs    = r_tx_rs;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_lcd_initseq_ctrl.sv
// Bench for lcd_initseq_ctrl: full 22-byte table on one instance, truncated 3-byte table on a second.
module tb_lcd_initseq_ctrl;

  typedef struct packed {
    logic [7:0] dat;
    logic       is_tx;
    logic       rs;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start, tx_ready, ser_idle;
  logic [4:0] rom_addr;
  logic [7:0] rom_data, tx_byte;
  logic       tx_valid, tx_rs, busy, done, err;

  logic       start_b, tx_ready_b, ser_idle_b;
  logic [1:0] rom_addr_b;
  logic [7:0] rom_data_b, tx_byte_b;
  logic       tx_valid_b, tx_rs_b, busy_b, done_b, err_b;

  logic [7:0] rom   [0:31];
  logic [7:0] rom_b [0:3];
  assign rom_data   = rom[rom_addr];
  assign rom_data_b = rom_b[rom_addr_b];

  lcd_initseq_ctrl #(.SEQ_LEN(22), .LONG_DLY_CYCLES(50), .SHORT_DLY_CYCLES(10), .CTR_W(24)) u_dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_rs(tx_rs),
    .ser_idle(ser_idle), .busy(busy), .done(done), .err(err)
  );

  lcd_initseq_ctrl #(.SEQ_LEN(3), .LONG_DLY_CYCLES(50), .SHORT_DLY_CYCLES(10), .CTR_W(24)) u_trunc (
    .clk(clk), .rst(rst), .start(start_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_byte(tx_byte_b), .tx_rs(tx_rs_b),
    .ser_idle(ser_idle_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] sb   [$];
  logic [8:0] sb_b [$];
  vec_t vecs [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(inout logic [8:0] q [$], input string nm, input logic [8:0] got);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s extra byte actual=%0h required=none", nm, got);
    end else begin
      chk(nm, {23'd0, got}, {23'd0, q.pop_front()});
    end
  endtask

  int         hs [16];
  int         nsent, vrise, idle_from, tcyc, nsent_b;
  logic       prev_stall, found;
  logic [8:0] prev_tx;

  initial begin
    rst = 1'b0; start = 1'b0; tx_ready = 1'b1; ser_idle = 1'b1;
    start_b = 1'b0; tx_ready_b = 1'b1; ser_idle_b = 1'b1;

    vecs = '{
      '{8'h01,1'b1,1'b0}, '{8'h40,1'b0,1'b0}, '{8'h11,1'b1,1'b0}, '{8'h40,1'b0,1'b0},
      '{8'h2A,1'b1,1'b0}, '{8'h04,1'b0,1'b0}, '{8'h00,1'b1,1'b1}, '{8'h00,1'b1,1'b1},
      '{8'h00,1'b1,1'b1}, '{8'h87,1'b1,1'b1}, '{8'h29,1'b1,1'b0}, '{8'h80,1'b0,1'b0},
      '{8'h2B,1'b1,1'b0}, '{8'h04,1'b0,1'b0}, '{8'h00,1'b1,1'b1}, '{8'h00,1'b1,1'b1},
      '{8'h01,1'b1,1'b1}, '{8'h3F,1'b1,1'b1}, '{8'h13,1'b1,1'b0}, '{8'h00,1'b0,1'b0},
      '{8'h29,1'b1,1'b0}, '{8'h00,1'b0,1'b0}
    };
    for (int i = 0; i < 32; i++) rom[i] = 8'hEE;
    for (int i = 0; i < 22; i++) rom[i] = vecs[i].dat;
    rom_b[0] = 8'h2A; rom_b[1] = 8'h04; rom_b[2] = 8'h00; rom_b[3] = 8'hEE;

    repeat (2) @(negedge clk);
    chk("rst_rom_addr", {27'd0, rom_addr}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_byte",  {24'd0, tx_byte},  32'd0);
    chk("rst_tx_rs",    {31'd0, tx_rs},    32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_err",      {31'd0, err},      32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Main run: expected byte stream queued as start is driven
    for (int i = 0; i < 22; i++)
      if (vecs[i].is_tx) sb.push_back({vecs[i].rs, vecs[i].dat});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy",  {31'd0, busy},     32'd1);
    chk("start_valid", {31'd0, tx_valid}, 32'd1);
    chk("start_byte",  {24'd0, tx_byte},  32'h01);

    nsent = 0; vrise = -1; idle_from = -100; prev_stall = 1'b0; prev_tx = '0;
    for (int i = 0; i < 16; i++) hs[i] = -1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      tx_ready = (nsent >= 9) ? 1'($urandom_range(0, 1)) : 1'b1;
      ser_idle = !(cyc > idle_from && cyc <= idle_from + 20);
      start    = (cyc == 10);
      if (prev_stall)
        chk("stall_hold", {22'd0, tx_valid, tx_rs, tx_byte}, {22'd0, 1'b1, prev_tx});
      if (tx_valid && nsent == 8 && vrise < 0) vrise = cyc;
      if (tx_valid && tx_ready) begin
        sb_pop(sb, $sformatf("byte%0d", nsent), {tx_rs, tx_byte});
        if (nsent < 16) hs[nsent] = cyc;
        if (nsent == 7) idle_from = cyc;
        nsent++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_tx    = {tx_rs, tx_byte};
      @(negedge clk);
    end
    start = 1'b0; tx_ready = 1'b1; ser_idle = 1'b1;

    chk("main_done",     {31'd0, done}, 32'd1);
    chk("main_err",      {31'd0, err},  32'd0);
    chk("main_busy",     {31'd0, busy}, 32'd0);
    chk("main_nsent",    nsent,         32'd15);
    chk("main_sb_empty", sb.size(),     32'd0);
    chk("t_cmd0",        hs[0],         32'd0);
    chk("t_long_dly0",   hs[1] - hs[0], 32'd52);
    chk("t_long_dly1",   hs[2] - hs[1], 32'd52);
    chk("t_caset_meta",  hs[3] - hs[2], 32'd2);
    chk("t_caset_a1",    hs[4] - hs[3], 32'd1);
    chk("t_caset_a2",    hs[5] - hs[4], 32'd1);
    chk("t_caset_a3",    hs[6] - hs[5], 32'd1);
    chk("t_no_dly",      hs[7] - hs[6], 32'd1);
    chk("t_drain_short", vrise - hs[7], 32'd31);

    // Async reset while an ARG byte is on offer, then replay from address 0
    sb.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      if (tx_valid && tx_rs) found = 1'b1;
      else @(negedge clk);
    end
    chk("arst_arg_seen", {31'd0, found}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("arst_tx_byte",  {24'd0, tx_byte},  32'd0);
    chk("arst_tx_rs",    {31'd0, tx_rs},    32'd0);
    chk("arst_rom_addr", {27'd0, rom_addr}, 32'd0);
    chk("arst_busy",     {31'd0, busy},     32'd0);
    chk("arst_done_err", {30'd0, done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("replay_addr",  {27'd0, rom_addr}, 32'd0);
    chk("replay_byte",  {23'd0, tx_rs, tx_byte}, 32'h001);
    chk("replay_valid", {31'd0, tx_valid}, 32'd1);

    // Truncated table: CMD 2A, META says 4 args, only one present
    sb_b.push_back({1'b0, 8'h2A});
    sb_b.push_back({1'b1, 8'h00});
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    tcyc = 0; nsent_b = 0;
    while (tcyc < 50 && !done_b) begin
      if (tx_valid_b && tx_ready_b) begin
        sb_pop(sb_b, $sformatf("trunc_byte%0d", nsent_b), {tx_rs_b, tx_byte_b});
        nsent_b++;
      end
      @(negedge clk);
      tcyc++;
    end
    chk("trunc_done_cyc", tcyc,          32'd4);
    chk("trunc_nsent",    nsent_b,       32'd2);
    chk("trunc_sb_empty", sb_b.size(),   32'd0);
    chk("trunc_err",      {31'd0, err_b},  32'd1);
    chk("trunc_done",     {31'd0, done_b}, 32'd1);
    chk("trunc_busy",     {31'd0, busy_b}, 32'd0);
    chk("trunc_valid",    {31'd0, tx_valid_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
